// File: rtl/mole_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mole_scheduler                                                |
// | Purpose  : Round controller for the three-mole whack-a-mole cabinet.     |
// |            Picks moles pseudo-randomly, times the gap/up/hit phases,     |
// |            scores hits, derives the level and runs the seconds countdown.|
// | Ports    : clk, rst (sync, active-low), start (pulse), bt_hit[2:0]       |
// |            (pulses) -> mole_en[2:0], score[9:0], level[1:0], timer[6:0], |
// |            hit_pulse, game_over; all outputs are registered.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mole_scheduler #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int SEC_TICKS   = 100,
  parameter int GAME_SEC    = 60,
  parameter int GAP_TICKS   = 50,
  parameter int UP_BASE     = 120,
  parameter int UP_STEP     = 25,
  parameter int HIT_TICKS   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] bt_hit,
  output logic [2:0] mole_en,
  output logic [9:0] score,
  output logic [1:0] level,
  output logic [6:0] timer,
  output logic       hit_pulse,
  output logic       game_over
);

  localparam int PRE_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SEC_W  = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int PH_MX1 = (GAP_TICKS > HIT_TICKS) ? GAP_TICKS : HIT_TICKS;
  localparam int PH_MAX = (UP_BASE > PH_MX1) ? UP_BASE : PH_MX1;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [9:0] SCORE_MAX = 10'd999;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_UP   = 3'd2,
    S_HIT  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [PH_W-1:0]    ph_q, ph_d;        // ticks spent in the current phase
  logic [7:0]         lfsr_q, lfsr_d;
  logic [1:0]         idx_q, idx_d;      // current mole; also "previous" for the next pick
  logic [1:0]         up_lvl_q, up_lvl_d; // level frozen at UP entry
  logic [2:0]         mole_en_q, mole_en_d;
  logic [9:0]         score_q, score_d;
  logic [1:0]         level_q, level_d;
  logic [6:0]         timer_q, timer_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               game_over_q, game_over_d;

  logic               tick;
  logic               sec_edge;
  logic               hit;
  logic               timer_zero;
  logic [1:0]         pick_idx;
  logic [PH_W-1:0]    up_last;
  logic [9:0]         score_sum;
  logic [9:0]         score_hit;

  function automatic logic [1:0] level_of(input logic [9:0] s);
    if (s < 10'd20)       return 2'd0;
    else if (s < 10'd50)  return 2'd1;
    else if (s < 10'd100) return 2'd2;
    else                  return 2'd3;
  endfunction

  always_comb begin
    tick       = (pre_q == PRE_W'(TICK_CYCLES - 1));
    sec_edge   = tick && (sec_q == SEC_W'(SEC_TICKS - 1));
    hit        = (state_q == S_UP) && bt_hit[idx_q];
    timer_zero = sec_edge && (timer_q == 7'd1);
    // Raw LFSR values 0..2 are used directly; 3 would bias, so step on instead.
    pick_idx   = (lfsr_q[1:0] != 2'd3) ? lfsr_q[1:0]
                                       : ((idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1);
    up_last    = PH_W'(UP_BASE - 1 - int'(up_lvl_q) * UP_STEP);
    // 999 + 4 still fits in 10 bits, so the saturation compare is exact.
    score_sum  = score_q + {8'd0, level_q} + 10'd1;
    score_hit  = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;

    state_d     = state_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pre_d       = tick ? '0 : pre_q + PRE_W'(1);
    sec_d       = tick ? (sec_edge ? '0 : sec_q + SEC_W'(1)) : sec_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    up_lvl_d    = up_lvl_q;
    mole_en_d   = mole_en_q;
    score_d     = score_q;
    level_d     = level_q;
    timer_d     = timer_q;
    hit_pulse_d = 1'b0;
    game_over_d = game_over_q;

    if (start) begin
      state_d     = S_GAP;
      pre_d       = '0;
      sec_d       = '0;
      ph_d        = '0;
      mole_en_d   = 3'd0;
      score_d     = 10'd0;
      level_d     = 2'd0;
      timer_d     = 7'(GAME_SEC);
      game_over_d = 1'b0;
    end else begin
      case (state_q)
        S_GAP, S_UP, S_HIT: begin
          if (tick)     ph_d    = ph_q + PH_W'(1);
          if (sec_edge) timer_d = timer_q - 7'd1;
          if (hit) begin
            score_d     = score_hit;
            level_d     = level_of(score_hit);
            hit_pulse_d = 1'b1;
          end
          // Countdown expiry outranks every phase transition; a hit on that
          // same edge has already been scored above.
          if (timer_zero) begin
            state_d     = S_OVER;
            mole_en_d   = 3'd0;
            game_over_d = 1'b1;
            ph_d        = '0;
          end else if (hit) begin
            state_d   = S_HIT;
            mole_en_d = 3'd0;
            ph_d      = '0;
          end else if (tick) begin
            case (state_q)
              S_GAP: begin
                if (ph_q == PH_W'(GAP_TICKS - 1)) begin
                  state_d   = S_UP;
                  idx_d     = pick_idx;
                  up_lvl_d  = level_q;
                  mole_en_d = 3'b001 << pick_idx;
                  ph_d      = '0;
                end
              end
              S_UP: begin
                if (ph_q == up_last) begin
                  state_d   = S_GAP;
                  mole_en_d = 3'd0;
                  ph_d      = '0;
                end
              end
              default: begin
                if (ph_q == PH_W'(HIT_TICKS - 1)) begin
                  state_d = S_GAP;
                  ph_d    = '0;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      sec_q       <= '0;
      ph_q        <= '0;
      lfsr_q      <= 8'hA5;
      idx_q       <= 2'd0;
      up_lvl_q    <= 2'd0;
      mole_en_q   <= 3'd0;
      score_q     <= 10'd0;
      level_q     <= 2'd0;
      timer_q     <= 7'd0;
      hit_pulse_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      sec_q       <= sec_d;
      ph_q        <= ph_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      up_lvl_q    <= up_lvl_d;
      mole_en_q   <= mole_en_d;
      score_q     <= score_d;
      level_q     <= level_d;
      timer_q     <= timer_d;
      hit_pulse_q <= hit_pulse_d;
      game_over_q <= game_over_d;
    end
  end

  assign mole_en   = mole_en_q;
  assign score     = score_q;
  assign level     = level_q;
  assign timer     = timer_q;
  assign hit_pulse = hit_pulse_q;
  assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Game-round controller for the whack-a-mole cabinet. It sequences the three electromagnet moles: pseudo-random selection, level-dependent up time and hit detection. It also owns score, level and the seconds countdown. It takes one-pulsed buttons and a one-pulsed start, and drives mole_en, the score and level shown on the 7-seg display, the timer shown on the countdown LEDs, and the hit trigger for the music block.

Parameters:
TICK_CYCLES, 1_000_000, clk cycles per game tick (10 ms at 100 MHz)
SEC_TICKS, 100, ticks per second of countdown
GAME_SEC, 60, round length in seconds (must be ≤127)
GAP_TICKS, 50, all-moles-down interval before each pop
UP_BASE, 120, mole up window in ticks at level 0
UP_STEP, 25, up window reduction per level (UP_BASE > 3*UP_STEP)
HIT_TICKS, 30, hold-down interval after a successful hit

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; starts or restarts a round
bt_hit  in  3  one-cycle pulses, bit i = button of mole i
mole_en  out  3  one-hot (or zero) electromagnet enable, registered
score  out  10  0..999, saturating
level  out  2  0..3
timer  out  7  seconds remaining
hit_pulse  out  1  one-cycle pulse per scored hit
game_over  out  1  high in OVER state

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, mole_en=0, score=0, level=0, timer=0, hit_pulse=0, game_over=0, LFSR=8'hA5, prescaler/counters=0. Applies from any state, including mid-round.
- Tick: prescaler counts 0..TICK_CYCLES-1 and emits a one-cycle tick at wrap. Second counter counts ticks 0..SEC_TICKS-1. Both clear on start.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clock in all states.
- Mole pick: idx = lfsr[1:0] if <3, else (prev_idx+1) mod 3. prev_idx resets to 0.
- States: IDLE, GAP, UP, HIT, OVER.
- IDLE: outputs idle. start → GAP with score=0, level=0, timer=GAME_SEC.
- GAP: mole_en=0. After GAP_TICKS ticks → UP, latching idx.
- UP: mole_en = 1<<idx from the first cycle in UP, registered.
  - bt_hit[idx]=1 → HIT, score += level+1 (saturate 999), hit_pulse=1 for one cycle, mole_en=0 next cycle.
  - Other bt_hit bits are ignored: no penalty, stay UP.
  - After UP_BASE − level*UP_STEP ticks without a hit → GAP (miss, no score change).
  - Hit and timeout in the same cycle: hit wins.
- HIT: mole_en=0. After HIT_TICKS ticks → GAP.
- Countdown: in GAP/UP/HIT, timer decrements at each second boundary. When timer becomes 0 → OVER from any of these states, mole_en=0 and game_over=1 on that same update.
  - Hit on the cycle timer reaches 0: score and hit_pulse still apply, then OVER.
- OVER: score, level and timer=0 held; bt_hit ignored. start → new round, identical to the IDLE start.
- start in GAP/UP/HIT restarts the round immediately: score=0, level=0, timer=GAME_SEC, state GAP, mole_en=0.
- Level is computed from the updated score in the same register update: <20 → 0, <50 → 1, <100 → 2, else 3. It therefore changes on the same clock as score.
- The current up window uses the level at UP entry.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use TICK_CYCLES=4, SEC_TICKS=5, GAME_SEC=3, GAP_TICKS=2, UP_BASE=6, UP_STEP=1, HIT_TICKS=1.

1. Reset: hold rst=0 with random start/bt_hit → mole_en=0, score=0, level=0, timer=0, game_over=0. After release with no start, bt_hit has no effect.
2. Hit: pulse start → timer=3. 8 cycles later exactly one mole_en bit set. Pulse the matching bt_hit → next edge score=1, hit_pulse high exactly 1 cycle, mole_en=0.
3. Miss/wrong button: pulse a non-matching bt_hit in UP → score unchanged, mole stays up. mole_en clears exactly 24 cycles after it rose; state returns to GAP.
4. Level: hit until score reaches 20 → level=1 on the same edge. Next hit gives score=22, and the following up window is 20 cycles. Force score to 998, hit at level 3 → score=999 (saturated).
5. Game end: 60 cycles after start → timer=0, game_over=1, mole_en=0. bt_hit ignored; score held. Pulse start → score=0, timer=3, game_over=0.
6. Corners:
   - Matching bt_hit on the UP timeout cycle → hit counted.
   - start mid-UP → mole_en=0, score=0 next edge.
   - rst=0 mid-UP → all outputs at reset values next edge.
